// File: rtl/rgb_pattern_pkg.sv
// Shared constants for the 3-3-2 RGB test-pattern generator: pattern
// selectors, black/white levels and the colour-bar lookup.
package rgb_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_PALETTE = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_RAMP    = 2'd3
  } mode_e;

  localparam logic [7:0] BLACK = 8'h00;
  localparam logic [7:0] WHITE = 8'hFF;

  // Bar 0 is leftmost: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0] BAR_COLOURS [8] = '{
    8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00
  };

  function automatic logic [7:0] bar_colour(input logic [2:0] idx);
    return BAR_COLOURS[idx];
  endfunction

endpackage

// File: rtl/rgb_pattern_window.sv
// First pipeline stage: window test and window-relative offsets, registered
// together with the incoming active flag.
module rgb_pattern_window #(
  parameter int X_BITS    = 10,
  parameter int Y_BITS    = 9,
  parameter int START_X   = 0,
  parameter int START_Y   = 0,
  parameter int TILE_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [X_BITS-1:0]    x_i,
  input  logic [Y_BITS-1:0]    y_i,
  input  logic                 active_i,
  output logic                 in_win_o,
  output logic [TILE_LOG2+4:0] xo_o,
  output logic [2:0]           ytile_o,
  output logic                 active_o
);

  localparam int XW     = X_BITS + 1;
  localparam int YW     = Y_BITS + 1;
  localparam int XO_W   = TILE_LOG2 + 5;
  localparam int X_SPAN = 1 << (TILE_LOG2 + 5);
  localparam int Y_SPAN = 1 << (TILE_LOG2 + 3);

  // One spare bit so neither the subtraction nor the span compare can wrap.
  logic [XW-1:0] x_ext, xo_ext;
  logic [YW-1:0] y_ext, yo_ext;
  logic          in_win_d;

  assign x_ext  = {1'b0, x_i};
  assign y_ext  = {1'b0, y_i};
  assign xo_ext = x_ext - XW'(START_X);
  assign yo_ext = y_ext - YW'(START_Y);

  assign in_win_d = (x_ext >= XW'(START_X)) && (y_ext >= YW'(START_Y)) &&
                    (xo_ext < XW'(X_SPAN))  && (yo_ext < YW'(Y_SPAN));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_win_o <= 1'b0;
      xo_o     <= '0;
      ytile_o  <= '0;
      active_o <= 1'b0;
    end else begin
      in_win_o <= in_win_d;
      xo_o     <= xo_ext[XO_W-1:0];
      ytile_o  <= yo_ext[TILE_LOG2+2:TILE_LOG2];
      active_o <= active_i;
    end
  end

endmodule

// File: rtl/rgb_pattern_gen.sv
// Registered 3-3-2 RGB test-pattern generator: two-stage pipeline from pixel
// coordinates to colour, with frame-synchronous mode select and animation.
module rgb_pattern_gen
  import rgb_pattern_pkg::*;
#(
  parameter int X_BITS     = 10,
  parameter int Y_BITS     = 9,
  parameter int START_X    = 0,
  parameter int START_Y    = 0,
  parameter int TILE_LOG2  = 4,
  parameter int FRAME_BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [X_BITS-1:0] x,
  input  logic [Y_BITS-1:0] y,
  input  logic              active_video,
  input  logic              frame_start,
  input  logic [1:0]        mode_req,
  input  logic              anim_en,
  output logic [7:0]        rgb,
  output logic              active_video_out,
  output logic [1:0]        mode_cur
);

  localparam int T    = TILE_LOG2;
  localparam int XO_W = T + 5;

  mode_e                 mode_cur_q;
  logic [FRAME_BITS-1:0] frame_cnt_q;

  logic                  in_win_s1;
  logic [XO_W-1:0]       xo_s1;
  logic [2:0]            ytile_s1;
  logic                  active_s1;
  mode_e                 mode_s1_q;
  logic [FRAME_BITS-1:0] cnt_s1_q;
  logic                  anim_s1_q;

  logic [7:0]            rgb_d;
  logic [XO_W-1:0]       ramp_s;
  logic [2:0]            ramp_v;
  logic                  checker_c;
  logic [7:0]            rgb_q;
  logic                  active_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_cur_q  <= MODE_PALETTE;
      frame_cnt_q <= '0;
    end else if (frame_start) begin
      mode_cur_q <= mode_e'(mode_req);
      if (anim_en) frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  rgb_pattern_window #(
    .X_BITS    (X_BITS),
    .Y_BITS    (Y_BITS),
    .START_X   (START_X),
    .START_Y   (START_Y),
    .TILE_LOG2 (TILE_LOG2)
  ) u_window (
    .clk      (clk),
    .rst_n    (rst_n),
    .x_i      (x),
    .y_i      (y),
    .active_i (active_video),
    .in_win_o (in_win_s1),
    .xo_o     (xo_s1),
    .ytile_o  (ytile_s1),
    .active_o (active_s1)
  );

  // Mode and count travel with the pixel, so a pixel coincident with
  // frame_start keeps the settings of the frame it belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_s1_q <= MODE_PALETTE;
      cnt_s1_q  <= '0;
      anim_s1_q <= 1'b0;
    end else begin
      mode_s1_q <= mode_cur_q;
      cnt_s1_q  <= frame_cnt_q;
      anim_s1_q <= anim_en;
    end
  end

  always_comb begin
    ramp_s    = xo_s1 + XO_W'(cnt_s1_q);
    ramp_v    = ramp_s[XO_W-1:XO_W-3];
    checker_c = xo_s1[T] ^ ytile_s1[0] ^ (anim_s1_q & cnt_s1_q[0]);
    rgb_d     = BLACK;
    case (mode_s1_q)
      MODE_PALETTE: rgb_d = {xo_s1[T+4:T+2], ytile_s1, xo_s1[T+1:T]};
      MODE_BARS:    rgb_d = bar_colour(xo_s1[T+4:T+2]);
      MODE_CHECKER: rgb_d = checker_c ? WHITE : BLACK;
      MODE_RAMP:    rgb_d = {ramp_v, ramp_v, ramp_v[2:1]};
      default:      rgb_d = BLACK;
    endcase
    if (!(active_s1 && in_win_s1)) rgb_d = BLACK;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_q    <= BLACK;
      active_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      active_q <= active_s1;
    end
  end

  assign rgb              = rgb_q;
  assign active_video_out = active_q;
  assign mode_cur         = mode_cur_q;

endmodule

// File: tb/tb_rgb_pattern_gen.sv
// Directed bench for rgb_pattern_gen: a default-parameter instance and an
// offset-window instance driven from shared stimulus tables.
module tb_rgb_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] x;
  logic [8:0] y;
  logic       active_video;
  logic       frame_start;
  logic [1:0] mode_req;
  logic       anim_en;

  logic [7:0] rgb1, rgb2;
  logic       avo1, avo2;
  logic [1:0] mode1, mode2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic       av;
    logic       fs;
    logic [1:0] mreq;
    logic       anim;
    logic [7:0] exp_rgb;
    logic       exp_avo;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  rgb_pattern_gen u_dut1 (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .active_video(active_video),
    .frame_start(frame_start), .mode_req(mode_req), .anim_en(anim_en),
    .rgb(rgb1), .active_video_out(avo1), .mode_cur(mode1)
  );

  rgb_pattern_gen #(.START_X(100), .START_Y(20), .TILE_LOG2(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .active_video(active_video),
    .frame_start(frame_start), .mode_req(mode_req), .anim_en(anim_en),
    .rgb(rgb2), .active_video_out(avo2), .mode_cur(mode2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    x = '0; y = '0; active_video = 1'b0; frame_start = 1'b0;
  endtask

  task automatic addv(input int xx, input int yy, input bit av, input bit fs,
                      input int mreq, input bit an, input int er, input bit ea);
    vec_t v;
    v.x = 10'(xx); v.y = 9'(yy); v.av = av; v.fs = fs;
    v.mreq = 2'(mreq); v.anim = an; v.exp_rgb = 8'(er); v.exp_avo = ea;
    vq.push_back(v);
  endtask

  // Vectors are issued back to back; each result is due exactly two edges
  // after its pixel, i.e. one loop iteration later.
  task automatic run_stream(input bit use2, input string tag);
    int n;
    logic [7:0] r;
    logic a;
    n = vq.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        x = vq[i].x; y = vq[i].y; active_video = vq[i].av;
        frame_start = vq[i].fs; mode_req = vq[i].mreq; anim_en = vq[i].anim;
      end else begin
        idle();
      end
      @(posedge clk); #1;
      if (i >= 1) begin
        r = use2 ? rgb2 : rgb1;
        a = use2 ? avo2 : avo1;
        $display("%s[%0d] x=%0d y=%0d av=%b fs=%b -> rgb=%h avo=%b (want %h %b)",
                 tag, i-1, vq[i-1].x, vq[i-1].y, vq[i-1].av, vq[i-1].fs,
                 r, a, vq[i-1].exp_rgb, vq[i-1].exp_avo);
        chk($sformatf("%s[%0d] rgb", tag, i-1), 32'(r), 32'(vq[i-1].exp_rgb));
        chk($sformatf("%s[%0d] avo", tag, i-1), 32'(a), 32'(vq[i-1].exp_avo));
      end
    end
    vq.delete();
  endtask

  task automatic pulse(input int mreq, input bit an);
    idle();
    frame_start = 1'b1; mode_req = 2'(mreq); anim_en = an;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] pal_y40(input int xx);
    logic [9:0] xv;
    xv = 10'(xx);
    return (xx < 512) ? {xv[8:6], 3'b010, xv[5:4]} : 8'h00;
  endfunction

  initial begin
    mode_req = 2'd0; anim_en = 1'b0;
    do_reset();

    chk("reset rgb", 32'(rgb1), 32'h00);
    chk("reset avo", 32'(avo1), 32'h0);
    chk("reset mode_cur", 32'(mode1), 32'h0);
    chk("reset rgb2", 32'(rgb2), 32'h00);
    $display("reset: rgb=%h avo=%b mode_cur=%0d", rgb1, avo1, mode1);

    // Offset window, tile 8, still palette mode after reset.
    addv( 99, 20, 1, 0, 0, 0, 8'h00, 1);
    addv(100, 20, 1, 0, 0, 0, 8'h00, 1);
    addv(140, 36, 1, 0, 0, 0, 8'h29, 1);
    addv(355, 20, 1, 0, 0, 0, 8'hE3, 1);
    addv(356, 20, 1, 0, 0, 0, 8'h00, 1);
    addv(100, 83, 1, 0, 0, 0, 8'h1C, 1);
    addv(100, 84, 1, 0, 0, 0, 8'h00, 1);
    addv(100, 19, 1, 0, 0, 0, 8'h00, 1);
    run_stream(1'b1, "win");

    // Default window, palette mode.
    addv(  80,  40, 1, 0, 0, 0, 8'h29, 1);
    addv( 511,  40, 1, 0, 0, 0, 8'hEB, 1);
    addv( 512,  40, 1, 0, 0, 0, 8'h00, 1);
    addv(  80, 127, 1, 0, 0, 0, 8'h3D, 1);
    addv(  80, 128, 1, 0, 0, 0, 8'h00, 1);
    addv(  80,  40, 0, 0, 0, 0, 8'h00, 0);
    addv(1023, 511, 1, 0, 0, 0, 8'h00, 1);
    run_stream(1'b0, "pal");

    // Continuous line sweep: every output must appear exactly two clocks later.
    for (int i = 0; i <= 640; i++) begin
      if (i < 640) begin
        x = 10'(i); y = 9'd40; active_video = 1'b1;
      end else begin
        idle();
      end
      @(posedge clk); #1;
      if (i >= 1) begin
        chk($sformatf("sweep x=%0d rgb", i-1), 32'(rgb1), 32'(pal_y40(i-1)));
        chk($sformatf("sweep x=%0d avo", i-1), 32'(avo1), 32'h1);
      end
    end
    $display("sweep: y=40 x=0..639 compared");

    // Bars; the pixel alongside the frame_start still renders as palette.
    addv( 80, 40, 1, 1, 1, 0, 8'h29, 1);
    addv(  0,  0, 1, 0, 1, 0, 8'hFF, 1);
    addv( 64,  0, 1, 0, 1, 0, 8'hFC, 1);
    addv(128,  0, 1, 0, 1, 0, 8'h1F, 1);
    addv(447,  0, 1, 0, 1, 0, 8'h03, 1);
    addv(448,  0, 1, 0, 1, 0, 8'h00, 1);
    addv( 64,  0, 1, 0, 2, 0, 8'hFC, 1);
    addv( 64,  0, 0, 0, 2, 0, 8'h00, 0);
    run_stream(1'b0, "bars");
    chk("bars mode_cur", 32'(mode1), 32'h1);
    $display("bars: mode_cur=%0d", mode1);

    // Ramp: five animated frames give frame_cnt=5.
    do_reset();
    for (int i = 0; i < 5; i++) pulse(3, 1'b1);
    chk("ramp mode_cur", 32'(mode1), 32'h3);
    addv(  0, 0, 1, 0, 3, 1, 8'h00, 1);
    addv( 58, 0, 1, 0, 3, 1, 8'h00, 1);
    addv( 59, 0, 1, 0, 3, 1, 8'h24, 1);
    addv(506, 0, 1, 0, 3, 1, 8'hFF, 1);
    addv(507, 0, 1, 0, 3, 1, 8'h00, 1);
    run_stream(1'b0, "ramp5");
    for (int i = 0; i < 251; i++) pulse(3, 1'b1);
    addv( 63, 0, 1, 0, 3, 1, 8'h00, 1);
    addv( 64, 0, 1, 0, 3, 1, 8'h24, 1);
    run_stream(1'b0, "ramp256");

    // Checker: phase follows frame_cnt[0] only while animated.
    do_reset();
    pulse(2, 1'b1);
    chk("checker mode_cur", 32'(mode1), 32'h2);
    addv( 0,  0, 1, 0, 2, 1, 8'hFF, 1);
    addv(16,  0, 1, 0, 2, 1, 8'h00, 1);
    addv(16, 16, 1, 0, 2, 1, 8'hFF, 1);
    run_stream(1'b0, "chk1");
    pulse(2, 1'b1);
    addv( 0,  0, 1, 0, 2, 1, 8'h00, 1);
    run_stream(1'b0, "chk2");
    pulse(2, 1'b0);
    addv( 0,  0, 1, 0, 2, 1, 8'h00, 1);
    run_stream(1'b0, "chkfrozen");
    pulse(2, 1'b1);
    addv( 0,  0, 1, 0, 2, 1, 8'hFF, 1);
    addv( 0,  0, 1, 0, 2, 0, 8'h00, 1);
    run_stream(1'b0, "chk3");

    // Reset asserted mid-line while a white pixel is in flight.
    x = 10'd0; y = 9'd0; active_video = 1'b1; anim_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset rgb", 32'(rgb1), 32'h00);
    chk("midreset avo", 32'(avo1), 32'h0);
    chk("midreset mode_cur", 32'(mode1), 32'h0);
    $display("midreset: rgb=%h avo=%b mode_cur=%0d", rgb1, avo1, mode1);
    rst_n = 1'b1;
    x = 10'd80; y = 9'd40;
    @(posedge clk); #1;
    chk("release+1 rgb", 32'(rgb1), 32'h00);
    chk("release+1 avo", 32'(avo1), 32'h0);
    @(posedge clk); #1;
    chk("release+2 rgb", 32'(rgb1), 32'h29);
    chk("release+2 avo", 32'(avo1), 32'h1);
    $display("release: rgb=%h avo=%b", rgb1, avo1);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
